// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC thermometer decoder.
// Optional bubble filter is enabled by defining TDC_BUBBLE_FILTER_EN.
package tdc_pkg;

    localparam int TDC_N        = 32;
    localparam int TDC_COARSE_W = 16;
    localparam int TDC_DROP_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        COUNT  = 2'd2,
        HOLD   = 2'd3
    } tdc_state_e;

    // Width needed to hold a count of 0..nt ones.
    function automatic int tdc_fine_w(input int nt);
        return $clog2(nt + 1);
    endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Combinational binary adder tree counting the ones in a NT-bit vector.
// Leaves beyond NT are padded with zero up to the next power of two.
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter int NT     = 128,
    parameter int FINE_W = tdc_fine_w(NT)
) (
    input  logic [NT-1:0]     bits,
    output logic [FINE_W-1:0] count
);

    localparam int LEVELS = (NT > 1) ? $clog2(NT) : 0;
    localparam int P      = 1 << LEVELS;

    genvar l, j;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            logic [FINE_W-1:0] s [P >> l];
            for (j = 0; j < (P >> l); j++) begin : g_node
                if (l == 0) begin : g_leaf
                    if (j < NT) begin : g_bit
                        assign s[j] = FINE_W'(bits[j]);
                    end else begin : g_pad
                        assign s[j] = '0;
                    end
                end else begin : g_add
                    assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
                end
            end
        end
    endgenerate

    assign count = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/tdc_therm_decoder.sv
// Captures a tap-chain thermometer code on hit, optionally bubble-filters it
// (TDC_BUBBLE_FILTER_EN), counts ones and pairs the result with a coarse time.
//
// state  | meaning
// IDLE   | waiting for hit; capture therm_in and coarse counter
// FILTER | majority filter (or pass-through) of captured code
// COUNT  | popcount and monotonic check into output registers
// HOLD   | out_valid high until out_ready handshake
module tdc_therm_decoder
    import tdc_pkg::*;
#(
    parameter int N        = TDC_N,
    parameter int COARSE_W = TDC_COARSE_W,
    parameter int FINE_W   = tdc_fine_w(N * 4),
    parameter int DROP_W   = TDC_DROP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N*4-1:0]      therm_in,
    input  logic                hit,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FINE_W-1:0]   fine_code,
    output logic [COARSE_W-1:0] coarse_code,
    output logic                mono_err,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam int NT = N * 4;

    tdc_state_e          state;
    logic [NT-1:0]       cap_r;
    logic [NT-1:0]       filt_r;
    logic [NT-1:0]       filt_next;
    logic [COARSE_W-1:0] coarse_cnt;
    logic [COARSE_W-1:0] coarse_r;
    logic [FINE_W-1:0]   pop_sum;
    logic                mono_next;

`ifdef TDC_BUBBLE_FILTER_EN
    // Boundaries: below tap 0 is treated as 1, above the last tap as 0.
    logic [NT+1:0] ext;

    always_comb begin
        ext       = {1'b0, cap_r, 1'b1};
        filt_next = '0;
        for (int i = 0; i < NT; i++) begin
            filt_next[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end
`else
    always_comb begin
        filt_next = cap_r;
    end
`endif

    // A set bit directly above a clear bit means the code is not a clean thermometer.
    assign mono_next = |(filt_r[NT-1:1] & ~filt_r[NT-2:0]);

    tdc_popcount #(
        .NT     (NT),
        .FINE_W (FINE_W)
    ) u_popcount (
        .bits  (filt_r),
        .count (pop_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_cnt <= '0;
        end else begin
            coarse_cnt <= coarse_cnt + COARSE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (hit && (state != IDLE) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cap_r       <= '0;
            coarse_r    <= '0;
            filt_r      <= '0;
            out_valid   <= 1'b0;
            fine_code   <= '0;
            coarse_code <= '0;
            mono_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        cap_r    <= therm_in;
                        coarse_r <= coarse_cnt;
                        state    <= FILTER;
                    end
                end
                FILTER: begin
                    filt_r <= filt_next;
                    state  <= COUNT;
                end
                COUNT: begin
                    fine_code   <= pop_sum;
                    coarse_code <= coarse_r;
                    mono_err    <= mono_next;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed self-checking bench for tdc_therm_decoder at default parameters.
module tb_tdc_therm_decoder;

    localparam int NT = 128;
    localparam int FW = 8;
    localparam int CW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NT-1:0] therm_in = '0;
    logic          hit = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [FW-1:0] fine_code;
    logic [CW-1:0] coarse_code;
    logic          mono_err;
    logic [DW-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] tb_coarse;
    int            cyc = 0;

    tdc_therm_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .therm_in    (therm_in),
        .hit         (hit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fine_code   (fine_code),
        .coarse_code (coarse_code),
        .mono_err    (mono_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_coarse <= '0;
        else        tb_coarse <= tb_coarse + 16'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NT-1:0] therm_ones(input int n);
        logic [NT-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Drives a one-cycle hit; returns at the negedge of cycle 1.
    task automatic send_hit(input logic [NT-1:0] v, output logic [CW-1:0] c, output int at_cyc);
        @(negedge clk);
        therm_in = v;
        hit      = 1'b1;
        c        = tb_coarse;
        at_cyc   = cyc;
        @(negedge clk);
        hit      = 1'b0;
    endtask

    // Called at the negedge of cycle 1; returns cycle index where out_valid is seen (10 = timeout).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({out_valid, fine_code, coarse_code, mono_err, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%0b fine=%0d coarse=%0d mono=%0b drop=%0d want all 0",
                     out_valid, fine_code, coarse_code, mono_err, drop_cnt);
        end
    endtask

    task automatic test_zero_code;
        logic [CW-1:0] c;
        int t, lat;
        out_ready = 1'b1;
        send_hit('0, c, t);
        wait_valid(lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL zero_latency: got %0d want 3", lat); end
        n_checks++;
        if (fine_code !== 8'd0 || mono_err !== 1'b0) begin
            n_fail++; $display("FAIL zero_fine: got fine=%0d mono=%0b want 0/0", fine_code, mono_err);
        end
        n_checks++;
        if (coarse_code !== c) begin n_fail++; $display("FAIL zero_coarse: got %0d want %0d", coarse_code, c); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_handshake: got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_all_ones;
        logic [CW-1:0] c;
        int t, lat;
        send_hit(therm_ones(NT), c, t);
        wait_valid(lat);
        n_checks++;
        if (lat !== 3 || fine_code !== 8'd128 || mono_err !== 1'b0) begin
            n_fail++; $display("FAIL all_ones: got lat=%0d fine=%0d mono=%0b want 3/128/0", lat, fine_code, mono_err);
        end
        @(negedge clk);
    endtask

    task automatic test_spacing;
        logic [CW-1:0] c0, c1, first_coarse;
        int t0, t1, lat;
        send_hit(therm_ones(37), c0, t0);
        wait_valid(lat);
        n_checks++;
        if (lat !== 3 || fine_code !== 8'd37 || mono_err !== 1'b0) begin
            n_fail++; $display("FAIL fine_37: got lat=%0d fine=%0d mono=%0b want 3/37/0", lat, fine_code, mono_err);
        end
        first_coarse = coarse_code;
        @(negedge clk);
        repeat (2) @(negedge clk);
        send_hit(therm_ones(100), c1, t1);
        wait_valid(lat);
        n_checks++;
        if (lat !== 3 || fine_code !== 8'd100 || coarse_code !== c1) begin
            n_fail++; $display("FAIL fine_100: got lat=%0d fine=%0d coarse=%0d want 3/100/%0d", lat, fine_code, coarse_code, c1);
        end
        n_checks++;
        if (int'(coarse_code - first_coarse) !== (t1 - t0)) begin
            n_fail++; $display("FAIL coarse_spacing: got %0d want %0d", coarse_code - first_coarse, t1 - t0);
        end
        @(negedge clk);
    endtask

    task automatic test_bubble;
        logic [CW-1:0] c;
        logic [NT-1:0] v;
        int t, lat;
        v = therm_ones(40);
        v[20] = 1'b0;
        send_hit(v, c, t);
        wait_valid(lat);
`ifdef TDC_BUBBLE_FILTER_EN
        n_checks++;
        if (fine_code !== 8'd40 || mono_err !== 1'b0) begin
            n_fail++; $display("FAIL bubble: got fine=%0d mono=%0b want 40/0", fine_code, mono_err);
        end
`else
        n_checks++;
        if (fine_code !== 8'd39 || mono_err !== 1'b1) begin
            n_fail++; $display("FAIL bubble: got fine=%0d mono=%0b want 39/1", fine_code, mono_err);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_drops;
        logic [CW-1:0] c;
        int t, lat;
        out_ready = 1'b0;
        send_hit(therm_ones(60), c, t);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hit = (i == 1 || i == 4 || i == 7);
        end
        n_checks++;
        if (out_valid !== 1'b1 || fine_code !== 8'd60 || coarse_code !== c) begin
            n_fail++; $display("FAIL hold_stable: got valid=%0b fine=%0d coarse=%0d want 1/60/%0d", out_valid, fine_code, coarse_code, c);
        end
        n_checks++;
        if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL drop_3: got %0d want 3", drop_cnt); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_release: got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_hit_on_handshake;
        logic [CW-1:0] c;
        int t, lat, seen;
        send_hit(therm_ones(5), c, t);
        wait_valid(lat);
        n_checks++;
        if (lat !== 3 || fine_code !== 8'd5) begin
            n_fail++; $display("FAIL hs_result: got lat=%0d fine=%0d want 3/5", lat, fine_code);
        end
        out_ready = 1'b1;
        hit       = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd4) begin
            n_fail++; $display("FAIL hs_drop: got valid=%0b drop=%0d want 0/4", out_valid, drop_cnt);
        end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL hs_no_bypass: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_saturate;
        logic [CW-1:0] c;
        int t, lat;
        out_ready = 1'b0;
        send_hit(therm_ones(8), c, t);
        wait_valid(lat);
        hit = 1'b1;
        repeat (250) @(negedge clk);
        n_checks++;
        if (drop_cnt !== 8'd254) begin n_fail++; $display("FAIL drop_254: got %0d want 254", drop_cnt); end
        repeat (50) @(negedge clk);
        hit = 1'b0;
        n_checks++;
        if (drop_cnt !== 8'd255 || out_valid !== 1'b1 || fine_code !== 8'd8) begin
            n_fail++; $display("FAIL drop_sat: got drop=%0d valid=%0b fine=%0d want 255/1/8", drop_cnt, out_valid, fine_code);
        end
    endtask

    task automatic test_reset_mid;
        logic [CW-1:0] c;
        int t, lat, seen;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send_hit(therm_ones(70), c, t);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || fine_code !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid: got valid=%0b drop=%0d fine=%0d want 0/0/0", out_valid, drop_cnt, fine_code);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_hold: got %0d valid cycles want 0", seen); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_hit(therm_ones(10), c, t);
        wait_valid(lat);
        n_checks++;
        if (lat !== 3 || fine_code !== 8'd10 || mono_err !== 1'b0 || coarse_code !== c) begin
            n_fail++; $display("FAIL after_reset: got lat=%0d fine=%0d mono=%0b coarse=%0d want 3/10/0/%0d",
                               lat, fine_code, mono_err, coarse_code, c);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_code();
        test_all_ones();
        test_spacing();
        test_bubble();
        test_drops();
        test_hit_on_handshake();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_therm_decoder.md
Name: tdc_therm_decoder

Overview:
- Receiving end of the tap-chain thermometer bus: captures the N*4-bit thermometer code on a hit strobe and applies bubble correction.
- Converts the code to a binary fine-time count and pairs it with a latched free-running coarse counter.
- Presents each result on a valid/ready output port; sits between the tap chain and the timestamp FIFO/readout logic.

Parameters:
- N, 32, number of tap cells; thermometer width NT = N*4 (default 128).
- COARSE_W, 16, width of the coarse counter.
- FINE_W, $clog2(N*4+1), width of the fine code (8 for default).
- DROP_W, 8, width of the saturating dropped-hit counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- therm_in  input  N*4  thermometer code from tap chain; stable in the hit cycle.
- hit  input  1  one-cycle pulse in clk domain: therm_in holds a valid sample.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- fine_code  output  FINE_W  number of ones after correction.
- coarse_code  output  COARSE_W  coarse count latched at hit.
- mono_err  output  1  corrected code still non-monotonic.
- drop_cnt  output  DROP_W  saturating count of hits rejected while busy.

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM=IDLE; out_valid=0, fine_code=0, coarse_code=0, mono_err=0, drop_cnt=0, coarse counter=0, all pipeline registers=0.
- Coarse counter: increments every clk, wraps modulo 2^COARSE_W.
- FSM states: IDLE, FILTER, COUNT, HOLD.
  - IDLE: on hit, register therm_in into cap_r and the current coarse value into coarse_r; go to FILTER.
  - FILTER: filt_r[i] = majority(cap[i-1], cap[i], cap[i+1]), boundaries cap[-1]=1, cap[NT]=0; go to COUNT.
  - COUNT: fine_r = popcount(filt_r). mono_err_r = 1 if any i has filt_r[i+1]=1 and filt_r[i]=0. Go to HOLD; out_valid rises on entry.
  - HOLD: out_valid=1; fine_code, coarse_code and mono_err are stable. When out_valid&&out_ready, return to IDLE and deassert out_valid in the next cycle.
- Latency: hit in cycle 0 gives out_valid=1 in cycle 3, with out_ready=1 giving one accepted result.
- Throughput: with out_ready held high, at most one result per 4 cycles.
- A hit in the same cycle as the HOLD handshake is dropped; no bypass.
- Drops: a hit in any state other than IDLE increments drop_cnt, saturating at all-ones. No other effect.
- Outputs are driven only from registers.
- Popcount arithmetic is unsigned, FINE_W wide; NT ones gives fine_code = NT exactly.
- Reset mid-operation aborts any in-flight sample and returns to reset values immediately.

Optional Feature:
- Macro TDC_BUBBLE_FILTER_EN.
- Defined: majority filter in FILTER as above.
- Undefined: FILTER copies cap_r to filt_r unchanged. The FILTER state and the 3-cycle latency are kept; mono_err still computed on filt_r.

Decomposition:
- Package tdc_pkg holds:
  - function clog2-based width helper;
  - FSM state enum (IDLE, FILTER, COUNT, HOLD);
  - default constants TDC_N=32, TDC_COARSE_W=16.
- One sub-module: tdc_popcount (parameterised width NT, combinational adder tree, output FINE_W), instantiated in COUNT.
- Filter and monotonic check stay inline.

Test Plan:
- Reset, then hit with therm_in=0 and out_ready=1: out_valid in cycle 3, fine_code=0, mono_err=0; coarse_code equals counter value at hit.
- therm_in all ones (128 bits): fine_code=128, mono_err=0.
- therm_in bits 0..36 set: fine_code=37. Second hit after handshake with bits 0..99 set: fine_code=100, coarse_code difference equals hit spacing.
- Bits 0..39 set with bit 20 cleared (bubble):
  - macro defined: fine_code=40, mono_err=0;
  - macro undefined: fine_code=39, mono_err=1.
- out_ready=0 for 10 cycles, 3 extra hits during HOLD: first result held unchanged, drop_cnt=3. Raise out_ready: one handshake, then IDLE. 300 extra hits: drop_cnt saturates at 255.
- rst_n asserted in COUNT: out_valid stays 0, drop_cnt=0. After release, a hit with bits 0..9 set returns fine_code=10 at cycle 3.
